// File: rtl/fix_trailer_checker.sv
// In-line FIX checksum checker: forwards bytes with one cycle of latency and reports the 10= trailer verdict.
// Optional macro FIX_PIPE_DELIM_EN: accept '|' (0x7C) as a field delimiter alongside SOH.
module fix_trailer_checker #(
    parameter int MAX_LEN = 255,
    parameter int LEN_W   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_end,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_end,
    output logic             chk_done,
    output logic             chk_ok,
    output logic [7:0]       chk_computed,
    output logic [7:0]       chk_received,
    output logic [LEN_W-1:0] msg_len,
    output logic             err_fmt,
    output logic             err_len
);

    typedef enum logic [2:0] {FLD_START, T1, T2, OTHER, DIG, DONE} state_e;

    // One extra counter bit so MAX_LEN+1 is representable even when 2^LEN_W == MAX_LEN+1.
    localparam int               CNT_W   = LEN_W + 1;
    localparam logic [CNT_W-1:0] LEN_SAT = CNT_W'(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    function automatic logic is_delim(input logic [7:0] b);
`ifdef FIX_PIPE_DELIM_EN
        return (b == 8'h01) || (b == 8'h7C);
`else
        return b == 8'h01;
`endif
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [7:0]       field_sum_q, field_sum_d;
    logic [7:0]       comp_q, comp_d;
    logic [9:0]       acc_q, acc_d;
    logic [2:0]       ndig_q, ndig_d;
    logic             fmt_err_q, fmt_err_d;

    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [7:0]       res_comp_q, res_comp_d;
    logic [7:0]       res_recv_q, res_recv_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic             res_efmt_q, res_efmt_d;
    logic             res_elen_q, res_elen_d;

    logic             out_valid_q, out_end_q;
    logic [7:0]       out_data_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        sum_d       = sum_q;
        len_d       = len_q;
        field_sum_d = field_sum_q;
        comp_d      = comp_q;
        acc_d       = acc_q;
        ndig_d      = ndig_q;
        fmt_err_d   = fmt_err_q;
        done_d      = 1'b0;
        ok_d        = ok_q;
        res_comp_d  = res_comp_q;
        res_recv_d  = res_recv_q;
        res_len_d   = res_len_q;
        res_efmt_d  = res_efmt_q;
        res_elen_d  = res_elen_q;

        if (in_valid) begin
            sum_d = sum_q + in_data;
            if (len_q != LEN_SAT) len_d = len_q + CNT_W'(1);
            case (state_q)
                FLD_START: begin
                    field_sum_d = sum_q;
                    if (in_data == 8'h31)      state_d = T1;
                    else if (!is_delim(in_data)) state_d = OTHER;
                end
                T1: state_d = (in_data == 8'h30) ? T2 : OTHER;
                T2: begin
                    if (in_data == 8'h3D) begin
                        state_d = DIG;
                        comp_d  = field_sum_q;
                    end else begin
                        state_d = OTHER;
                    end
                end
                OTHER: if (is_delim(in_data)) state_d = FLD_START;
                DIG: begin
                    if (in_data >= 8'h30 && in_data <= 8'h39) begin
                        acc_d = (acc_q * 10'd10) + {6'd0, in_data[3:0]};
                        if (ndig_q != 3'd7) ndig_d = ndig_q + 3'd1;
                    end else if (is_delim(in_data)) begin
                        state_d = DONE;
                        if (!(ndig_q == 3'd3 && acc_q <= 10'd255)) fmt_err_d = 1'b1;
                    end else begin
                        fmt_err_d = 1'b1;
                        state_d   = OTHER;
                    end
                end
                DONE:    fmt_err_d = 1'b1;
                default: state_d = FLD_START;
            endcase
        end

        // Results take the byte of this cycle into account before the message closes.
        if (in_end) begin
            done_d     = 1'b1;
            res_len_d  = len_d[LEN_W-1:0];
            res_recv_d = acc_d[7:0];
            res_comp_d = comp_d;
            res_efmt_d = fmt_err_d || (state_d != DONE);
            res_elen_d = len_d > LEN_MAX;
            ok_d       = !res_efmt_d && !res_elen_d && (comp_d == acc_d[7:0]);
            sum_d      = 8'h00;
            len_d      = '0;
            acc_d      = 10'd0;
            ndig_d     = 3'd0;
            fmt_err_d  = 1'b0;
            state_d    = FLD_START;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FLD_START;
            sum_q       <= 8'h00;
            len_q       <= '0;
            field_sum_q <= 8'h00;
            comp_q      <= 8'h00;
            acc_q       <= 10'd0;
            ndig_q      <= 3'd0;
            fmt_err_q   <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            res_comp_q  <= 8'h00;
            res_recv_q  <= 8'h00;
            res_len_q   <= '0;
            res_efmt_q  <= 1'b0;
            res_elen_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_end_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            field_sum_q <= field_sum_d;
            comp_q      <= comp_d;
            acc_q       <= acc_d;
            ndig_q      <= ndig_d;
            fmt_err_q   <= fmt_err_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            res_comp_q  <= res_comp_d;
            res_recv_q  <= res_recv_d;
            res_len_q   <= res_len_d;
            res_efmt_q  <= res_efmt_d;
            res_elen_q  <= res_elen_d;
            out_valid_q <= in_valid;
            out_data_q  <= in_data;
            out_end_q   <= in_end;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_end      = out_end_q;
    assign chk_done     = done_q;
    assign chk_ok       = ok_q;
    assign chk_computed = res_comp_q;
    assign chk_received = res_recv_q;
    assign msg_len      = res_len_q;
    assign err_fmt      = res_efmt_q;
    assign err_len      = res_elen_q;

endmodule

// File: tb/tb_fix_trailer_checker.sv
// Directed bench for fix_trailer_checker: a default instance plus a MAX_LEN=8 instance on the same stream.
// In message strings '^' stands for SOH (0x01).
module tb_fix_trailer_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_end = 1'b0;

    logic       out_valid, out_end, chk_done, chk_ok, err_fmt, err_len;
    logic [7:0] out_data, chk_computed, chk_received;
    logic [8:0] msg_len;

    logic       s_out_valid, s_out_end, s_chk_done, s_chk_ok, s_err_fmt, s_err_len;
    logic [7:0] s_out_data, s_chk_computed, s_chk_received;
    logic [3:0] s_msg_len;

    int   checks = 0;
    int   failures = 0;
    bit   pass_chk = 1'b0;
    logic       exp_v = 1'b0;
    logic [7:0] exp_d = 8'h00;

    fix_trailer_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
        .out_valid(out_valid), .out_data(out_data), .out_end(out_end),
        .chk_done(chk_done), .chk_ok(chk_ok), .chk_computed(chk_computed),
        .chk_received(chk_received), .msg_len(msg_len), .err_fmt(err_fmt), .err_len(err_len)
    );

    fix_trailer_checker #(.MAX_LEN(8), .LEN_W(4)) dut_short (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_end(s_out_end),
        .chk_done(s_chk_done), .chk_ok(s_chk_ok), .chk_computed(s_chk_computed),
        .chk_received(s_chk_received), .msg_len(s_msg_len), .err_fmt(s_err_fmt), .err_len(s_err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one cycle at the falling edge; optionally checks the short instance's passthrough first.
    task automatic step(input logic v, input logic [7:0] d, input logic e);
        @(negedge clk);
        if (pass_chk) begin
            check("pass_valid", {31'd0, s_out_valid}, {31'd0, exp_v});
            if (exp_v) check("pass_data", {24'd0, s_out_data}, {24'd0, exp_d});
        end
        in_valid = v;
        in_data  = d;
        in_end   = e;
        exp_v    = v;
        exp_d    = d;
    endtask

    task automatic send(input string s, input bit merge);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] d;
            d = s[i];
            if (d == 8'h5E) d = 8'h01;
            step(1'b1, d, merge && (i == s.len() - 1));
        end
        if (!merge) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("done_pulse", {31'd0, chk_done}, 32'd1);
        check("out_end", {31'd0, out_end}, 32'd1);
    endtask

    task automatic check_res(input string t, input logic ok, input logic efmt, input logic elen,
                             input int len);
        check({t, "_ok"}, {31'd0, chk_ok}, {31'd0, ok});
        check({t, "_err_fmt"}, {31'd0, err_fmt}, {31'd0, efmt});
        check({t, "_err_len"}, {31'd0, err_len}, {31'd0, elen});
        check({t, "_len"}, {23'd0, msg_len}, len);
    endtask

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_end", {31'd0, out_end}, 32'd0);
        check("rst_done", {31'd0, chk_done}, 32'd0);
        check("rst_ok", {31'd0, chk_ok}, 32'd0);
        check("rst_err_fmt", {31'd0, err_fmt}, 32'd0);
        check("rst_err_len", {31'd0, err_len}, 32'd0);
        check("rst_computed", {24'd0, chk_computed}, 32'd0);
        check("rst_received", {24'd0, chk_received}, 32'd0);
        check("rst_len", {23'd0, msg_len}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Valid trailer; the short instance also checks passthrough and length overflow.
        pass_chk = 1'b1;
        send("A^10=066^", 1'b0);
        pass_chk = 1'b0;
        check_res("valid", 1'b1, 1'b0, 1'b0, 9);
        check("valid_comp", {24'd0, chk_computed}, 32'h42);
        check("valid_recv", {24'd0, chk_received}, 32'h42);
        check("short_err_len", {31'd0, s_err_len}, 32'd1);
        check("short_ok", {31'd0, s_chk_ok}, 32'd0);
        check("short_len", {28'd0, s_msg_len}, 32'd9);
        @(negedge clk);
        check("done_single", {31'd0, chk_done}, 32'd0);
        check("hold_ok", {31'd0, chk_ok}, 32'd1);

        send("A^10=067^", 1'b0);
        check_res("wrong", 1'b0, 1'b0, 1'b0, 9);
        check("wrong_comp", {24'd0, chk_computed}, 32'h42);
        check("wrong_recv", {24'd0, chk_received}, 32'h43);

        send("A^10=6^", 1'b0);
        check_res("one_digit", 1'b0, 1'b1, 1'b0, 7);
        check("short_7_err_len", {31'd0, s_err_len}, 32'd0);

        send("A^10=300^", 1'b0);
        check_res("over_255", 1'b0, 1'b1, 1'b0, 9);

        send("A^", 1'b0);
        check_res("no_trailer", 1'b0, 1'b1, 1'b0, 2);

        send("A^10=066^X", 1'b0);
        check_res("after_done", 1'b0, 1'b1, 1'b0, 10);

        send("A|10=189|", 1'b0);
`ifdef FIX_PIPE_DELIM_EN
        check_res("pipe", 1'b1, 1'b0, 1'b0, 9);
        check("pipe_comp", {24'd0, chk_computed}, 32'hBD);
`else
        check_res("pipe", 1'b0, 1'b1, 1'b0, 9);
`endif

        send("", 1'b0);
        check_res("empty", 1'b0, 1'b1, 1'b0, 0);

        send("A^10=066^", 1'b1);
        check_res("merged_end", 1'b1, 1'b0, 1'b0, 9);

        // Reset mid-message after three bytes.
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h31, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ok", {31'd0, chk_ok}, 32'd0);
        check("mid_rst_len", {23'd0, msg_len}, 32'd0);
        check("mid_rst_comp", {24'd0, chk_computed}, 32'd0);
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_v    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b1;
            check("mid_rst_no_done", {31'd0, chk_done}, 32'd0);
        end
        send("A^10=066^", 1'b0);
        check_res("after_rst", 1'b1, 1'b0, 1'b0, 9);
        check("after_rst_comp", {24'd0, chk_computed}, 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fix_trailer_checker.md
# fix_trailer_checker

In-line checker on the outbound FIX byte stream between the initiator/acceptor message engine and the console's RAM writer. It forwards each byte unchanged with one cycle of latency. While forwarding, it sums every byte, finds the `10=` trailer field, and decodes its three ASCII digits. When the message ends it reports the computed checksum, the received checksum, the message length and a pass/fail verdict.

## Interface
Parameters:
- `MAX_LEN`, default 255: maximum message length in bytes, trailer included.
- `LEN_W`, default 9: width of `msg_len`; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: byte strobe, one byte per asserted cycle.
- `in_data` input 8: message byte.
- `in_end` input 1: single-cycle end-of-message strobe.
- `out_valid` output 1: `in_valid` delayed 1 cycle.
- `out_data` output 8: `in_data` delayed 1 cycle.
- `out_end` output 1: `in_end` delayed 1 cycle.
- `chk_done` output 1: single-cycle pulse; the result outputs are valid in this cycle.
- `chk_ok` output 1: no error, and computed checksum equals received checksum.
- `chk_computed` output 8: sum mod 256 of all bytes before the `1` of the `10=` field.
- `chk_received` output 8: decoded trailer value.
- `msg_len` output LEN_W: bytes counted in the message.
- `err_fmt` output 1: trailer missing or malformed.
- `err_len` output 1: message longer than MAX_LEN.

## Operation
- The delimiter is SOH (0x01).
- Running registers:
  - `sum`: 8-bit, wraps, adds every byte.
  - `len`: saturates at MAX_LEN+1.
  - `field_sum`: holds `sum` as it stood before the first byte of the current field.
- FSM states and transitions:
  - FLD_START: on `1` go to T1; on delimiter stay; on any other byte go to OTHER.
  - T1: on `0` go to T2; otherwise go to OTHER.
  - T2: on `=` go to DIG and latch `chk_computed` := `field_sum`; otherwise go to OTHER.
  - OTHER: on delimiter go to FLD_START.
  - DIG: on an ASCII digit, acc := acc*10 + digit (10-bit accumulator), ndig++.
  - DIG, on delimiter: go to DONE. Format is good only if ndig==3 and acc<=255.
  - DIG, on any other byte: set the format error and go to OTHER.
  - DONE: any further byte before `in_end` sets the format error.
- Error conditions:
  - `err_fmt` is set if DONE was never reached, or if any of the format errors above occurred.
  - `err_len` is set if `len` > MAX_LEN.
- On `in_end`:
  - Latch `msg_len`, `chk_received` (acc[7:0]), both error flags and `chk_ok`.
  - Pulse `chk_done`.
  - Clear `sum`, `len`, `acc` and `ndig`; return the FSM to FLD_START.
- Results hold until the next `chk_done`.
- `in_valid` and `in_end` in the same cycle: the byte is included in the message, then the message closes.
- `in_end` with no bytes received: `msg_len`=0, `err_fmt`=1, `chk_ok`=0.

## Timing
- Data path: 1-cycle latency; no backpressure; one byte accepted every cycle.
- `chk_done` is asserted in the same cycle as `out_end`, one cycle after `in_end`.
- Reset values:
  - `out_valid`, `out_end`, `chk_done`, `chk_ok`, `err_fmt`, `err_len`: 0.
  - `out_data`, `chk_computed`, `chk_received`: 8'h00.
  - `msg_len`: 0.
  - FSM: FLD_START.
- Reset mid-message: the partial message is discarded with no `chk_done` pulse. The first byte after reset release starts a new message.

## Configuration
- `FIX_PIPE_DELIM_EN`:
  - Defined: `|` (0x7C) is accepted as a delimiter in addition to SOH, everywhere SOH is accepted.
  - Undefined: only SOH is a delimiter, and `|` is an ordinary byte.

## Test plan
- Valid checksum: "A",SOH,"10=066",SOH, then `in_end`. Required: `chk_done` 1 cycle later; `chk_computed`=0x42, `chk_received`=0x42, `msg_len`=9, `chk_ok`=1, both errors 0.
- Wrong checksum: "A",SOH,"10=067",SOH. Required: `chk_computed`=0x42, `chk_received`=0x43, `chk_ok`=0, `err_fmt`=0.
- Malformed trailers:
  - "A",SOH,"10=6",SOH requires `err_fmt`=1.
  - "A",SOH,"10=300",SOH requires `err_fmt`=1.
  - "A",SOH with no trailer requires `err_fmt`=1, `msg_len`=2.
- Length limit: MAX_LEN=8 with the 9-byte valid message. Required: `err_len`=1, `chk_ok`=0. Passthrough `out_data` must match the input byte-for-byte, delayed 1 cycle.
- Pipe delimiter: "A|10=189|".
  - With `FIX_PIPE_DELIM_EN` defined: `chk_computed`=0xBD, `chk_ok`=1.
  - Without it: `err_fmt`=1.
- Reset and boundary:
  - Drop `reset` after 3 bytes. Required: outputs clear immediately; no `chk_done`; the next valid message checks OK.
  - Assert `in_valid` and `in_end` together on the final SOH. Required: `chk_ok`=1.
